ldpe_pipe_bank: RTL and testbench

//  Parametrised successor to the single-bit preset latch: a WIDTH-bit, DEPTH-stage

---
 rtl/ldpe_pipe_bank.sv | 75 +++++++
 tb/tb_ldpe_pipe_bank.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ldpe_pipe_bank.sv
// ldpe_pipe_bank: WIDTH x DEPTH gated delay line with async preset and valid count.
// Optional macro LDPE_PIPE_BYPASS_EN adds BYP, a transparent D->Q path.
module ldpe_pipe_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}},
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic             C,
  input  logic             PRE,
  input  logic             GE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
`ifdef LDPE_PIPE_BYPASS_EN
  input  logic             BYP,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [CW-1:0]    CNT
);

  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic [CW-1:0]    cnt;

  // data stages: preset to INIT, otherwise shift on GE; FLUSH leaves data alone
  always_ff @(posedge C or posedge PRE) begin
    if (PRE) begin
      for (int i = 0; i < DEPTH; i++)
        s[i] <= INIT;
    end else if (!FLUSH && GE) begin
      s[0] <= D;
      for (int i = 1; i < DEPTH; i++)
        s[i] <= s[i-1];
    end
  end

  // valid bits and running count move together so CNT always equals popcount(v)
  always_ff @(posedge C or posedge PRE) begin
    if (PRE) begin
      v   <= '0;
      cnt <= '0;
    end else if (FLUSH) begin
      v   <= '0;
      cnt <= '0;
    end else if (GE) begin
      v[0] <= DV;
      for (int i = 1; i < DEPTH; i++)
        v[i] <= v[i-1];
      cnt <= cnt + CW'(DV) - CW'(v[DEPTH-1]);
    end
  end

  assign CNT = cnt;

`ifdef LDPE_PIPE_BYPASS_EN
  // bypass is transparent only outside preset; preset already forces s to INIT
  always_comb begin
    Q  = s[DEPTH-1];
    QV = v[DEPTH-1];
    if (BYP && !PRE) begin
      Q  = D;
      QV = DV;
    end
  end
`else
  // outputs come straight from the last stage
  always_comb begin
    Q  = s[DEPTH-1];
    QV = v[DEPTH-1];
  end
`endif

endmodule

// File: tb/tb_ldpe_pipe_bank.sv
// tb_ldpe_pipe_bank: directed plus random stimulus against a queue-based model.
// Define LDPE_PIPE_BYPASS_EN on both files to exercise the bypass path.
module tb_ldpe_pipe_bank;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] INIT = 8'hFF;

  logic C = 1'b0;
  logic PRE, GE, FLUSH, DV;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic QV;
  logic [CW-1:0] CNT;
`ifdef LDPE_PIPE_BYPASS_EN
  logic BYP = 1'b0;
`endif

  int passes = 0;
  int total = 0;
  int fails = 0;

  logic [WIDTH-1:0] md[$];
  bit mv[$];

  ldpe_pipe_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT(INIT)) dut (
    .C(C),
    .PRE(PRE),
    .GE(GE),
    .FLUSH(FLUSH),
    .D(D),
    .DV(DV),
`ifdef LDPE_PIPE_BYPASS_EN
    .BYP(BYP),
`endif
    .Q(Q),
    .QV(QV),
    .CNT(CNT)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md.delete();
    mv.delete();
    for (int i = 0; i < DEPTH; i++) begin
      md.push_back(INIT);
      mv.push_back(1'b0);
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    foreach (mv[i]) n += int'(mv[i]);
    return n;
  endfunction

  task automatic model_edge();
    if (FLUSH) begin
      foreach (mv[i]) mv[i] = 1'b0;
    end else if (GE) begin
      md.push_front(D);
      void'(md.pop_back());
      mv.push_front(DV);
      void'(mv.pop_back());
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_q"}, int'(Q), int'(md[DEPTH-1]));
    chk({tag, "_qv"}, int'(QV), int'(mv[DEPTH-1]));
    chk({tag, "_cnt"}, int'(CNT), model_cnt());
  endtask

  task automatic step(input logic ge, input logic fl,
                      input logic [WIDTH-1:0] d, input logic dv,
                      input string tag);
    GE = ge;
    FLUSH = fl;
    D = d;
    DV = dv;
    @(posedge C);
    model_edge();
    #1;
    chk_model(tag);
  endtask

  task automatic pre_pulse(input string tag);
    #2 PRE = 1'b1;
    #1;
    model_reset();
    chk({tag, "_q"}, int'(Q), int'(INIT));
    chk({tag, "_qv"}, int'(QV), 0);
    chk({tag, "_cnt"}, int'(CNT), 0);
    #1 PRE = 1'b0;
  endtask

  initial begin
    PRE = 1'b1;
    GE = 1'b0;
    FLUSH = 1'b0;
    D = '0;
    DV = 1'b0;
    model_reset();
    #12;
    chk("rst_q", int'(Q), 8'hFF);
    chk("rst_qv", int'(QV), 0);
    chk("rst_cnt", int'(CNT), 0);
    @(posedge C);
    #1 PRE = 1'b0;

    // five-word stream, full latency
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b1, "stream");
      chk("stream_cnt_c", int'(CNT), (i < 4) ? i : 4);
      if (i == 4) begin
        chk("lat4_q", int'(Q), 8'h01);
        chk("lat4_qv", int'(QV), 1);
      end
    end

    // flush with GE=1: valids drop, data held
    pre_pulse("pre_a");
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b0, 8'(i), 1'b1, "fill");
    chk("full_cnt", int'(CNT), 4);
    step(1'b1, 1'b1, 8'h77, 1'b1, "flush");
    chk("flush_cnt", int'(CNT), 0);
    chk("flush_qv", int'(QV), 0);
    chk("flush_q", int'(Q), 8'h01);
    step(1'b1, 1'b0, 8'h88, 1'b1, "postflush");
    chk("postflush_q", int'(Q), 8'h02);
    chk("postflush_cnt", int'(CNT), 1);

    // GE=0 on the third edge delays the first word by one edge
    pre_pulse("pre_b");
    step(1'b1, 1'b0, 8'h01, 1'b1, "gate");
    step(1'b1, 1'b0, 8'h02, 1'b1, "gate");
    step(1'b0, 1'b0, 8'h03, 1'b1, "gate_off");
    chk("gate_off_cnt", int'(CNT), 2);
    step(1'b1, 1'b0, 8'h03, 1'b1, "gate");
    chk("gate_q_notyet", int'(QV), 0);
    step(1'b1, 1'b0, 8'h04, 1'b1, "gate");
    chk("gate_q", int'(Q), 8'h01);
    chk("gate_qv", int'(QV), 1);

    // preset mid-stream at CNT=3, then resume
    pre_pulse("pre_c");
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 8'(8'h10 + i), 1'b1, "mid");
    chk("mid_cnt", int'(CNT), 3);
    pre_pulse("pre_mid");
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 8'(8'h20 + i), 1'(i != 1), "resume");
    chk("resume_q", int'(Q), 8'h20);
    chk("resume_cnt", int'(CNT), 3);

`ifdef LDPE_PIPE_BYPASS_EN
    GE = 1'b0;
    D = 8'hA5;
    DV = 1'b1;
    BYP = 1'b1;
    #1;
    chk("byp_q", int'(Q), 8'hA5);
    chk("byp_qv", int'(QV), 1);
    BYP = 1'b0;
    #1;
    chk_model("byp_off");
`endif

    // random traffic
    for (int n = 0; n < 300; n++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
           8'($urandom), 1'($urandom), "rand");
      if ($urandom_range(0, 39) == 0)
        pre_pulse("rand_pre");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
